truth_table_checker: RTL and testbench

Sequential response checker for exhaustive combinational tests: the receiving end of a stimulus source that walks every input combination of an N-input Boolean function. Each applied vector and the DUT response are sampled, compared against a parameterised expected truth table, and tracked until every combination has been seen. It then reports a pass/fail verdict, the error count and the first failing index. Used in the lab benches downstream of the stimulus process, and synthesisable for on-board self-checking.

---
 rtl/truth_table_checker_if.sv | 65 ++++++
 rtl/truth_table_checker.sv | 183 ++++++++++++++++++
 tb/tb_truth_table_checker.sv | 387 ++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/truth_table_checker_if.sv
// -----------------------------------------------------------------------------
// truth_table_checker_if
//
// Purpose: groups the sample stream and the verdict signals of the
// truth-table response checker into one bundle.
//
// Signals:
//   start            source -> checker  begin a check run
//   vec_valid        source -> checker  vec/resp hold a settled sample
//   vec[N_IN]        source -> checker  input combination applied to the DUT
//   resp             source -> checker  DUT output for vec
//   busy             checker -> source  run in progress
//   done             checker -> source  run complete
//   pass             checker -> source  done with no errors
//   err_count[CNT_W] checker -> source  saturating mismatch count
//   first_err_valid  checker -> source  at least one mismatch recorded
//   first_err_idx    checker -> source  vec of the first mismatch
//   order_err        checker -> source  out-of-order sample seen
//                                       (present only with CHK_ORDER_EN)
//
// Modports: master = stimulus/observer side, slave = checker side.
// Optional feature macro: CHK_ORDER_EN.
// -----------------------------------------------------------------------------
interface truth_table_checker_if #(
    parameter int N_IN  = 4,
    parameter int CNT_W = 8
) ();

    logic             start;
    logic             vec_valid;
    logic [N_IN-1:0]  vec;
    logic             resp;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic             first_err_valid;
    logic [N_IN-1:0]  first_err_idx;
`ifdef CHK_ORDER_EN
    logic             order_err;

    modport master (
        output start, vec_valid, vec, resp,
        input  busy, done, pass, err_count, first_err_valid, first_err_idx,
               order_err
    );

    modport slave (
        input  start, vec_valid, vec, resp,
        output busy, done, pass, err_count, first_err_valid, first_err_idx,
               order_err
    );
`else
    modport master (
        output start, vec_valid, vec, resp,
        input  busy, done, pass, err_count, first_err_valid, first_err_idx
    );

    modport slave (
        input  start, vec_valid, vec, resp,
        output busy, done, pass, err_count, first_err_valid, first_err_idx
    );
`endif

endinterface

// File: rtl/truth_table_checker.sv
// -----------------------------------------------------------------------------
// truth_table_checker
//
// Purpose: receiving end of an exhaustive combinational test. Every sample
// (vec, resp) taken while a run is active is compared against the expected
// truth table EXPECTED and marked in a coverage bitmap. When every input
// combination has been seen, the run completes and the checker reports a
// verdict, the saturating error count and the first failing input vector.
//
// Parameters:
//   N_IN      number of DUT inputs (truth table has 2^N_IN entries)
//   EXPECTED  bit i is the required response for input vector i
//   CNT_W     width of the saturating error counter
//
// Ports:
//   clk  system clock, all state changes on the rising edge
//   rst  synchronous active-high reset, overrides start and vec_valid
//   chk  truth_table_checker_if.slave: start/vec_valid/vec/resp in,
//        busy/done/pass/err_count/first_err_valid/first_err_idx out
//        (+ order_err when CHK_ORDER_EN is defined)
//
// Optional feature macro: CHK_ORDER_EN -- adds an in-order check. A
// next-index counter follows every sample (vec+1, wrapping); any sample
// whose vec differs from it sets a sticky order_err, which forces pass low.
// -----------------------------------------------------------------------------
module truth_table_checker #(
    parameter int                     N_IN     = 4,
    parameter logic [(1<<N_IN)-1:0]   EXPECTED = 16'h6996,
    parameter int                     CNT_W    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    truth_table_checker_if.slave  chk
);

    localparam int N_VEC = 1 << N_IN;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_e;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    state_e           state_q,           state_d;
    logic [N_VEC-1:0] seen_q,            seen_d;
    logic [CNT_W-1:0] err_cnt_q,         err_cnt_d;
    logic             first_err_valid_q, first_err_valid_d;
    logic [N_IN-1:0]  first_err_idx_q,   first_err_idx_d;
`ifdef CHK_ORDER_EN
    logic [N_IN-1:0]  next_idx_q,        next_idx_d;
    logic             order_err_q,       order_err_d;
`endif

    // -------------------------------------------------------------------------
    // Sample decode
    // -------------------------------------------------------------------------
    logic [N_VEC-1:0] vec_onehot;
    logic             mismatch;
    logic             err_cnt_full;

    assign vec_onehot   = N_VEC'(1) << chk.vec;
    assign mismatch     = (chk.resp != EXPECTED[chk.vec]);
    assign err_cnt_full = (err_cnt_q == {CNT_W{1'b1}});

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal driven here gets a hold value first, so no path
        // through the case leaves it unassigned and no latch is inferred.
        state_d           = state_q;
        seen_d            = seen_q;
        err_cnt_d         = err_cnt_q;
        first_err_valid_d = first_err_valid_q;
        first_err_idx_d   = first_err_idx_q;
`ifdef CHK_ORDER_EN
        next_idx_d        = next_idx_q;
        order_err_d       = order_err_q;
`endif

        unique case (state_q)
            // IDLE and DONE behave alike: samples are ignored, results hold,
            // and start opens a fresh run with all run state cleared.
            S_IDLE, S_DONE: begin
                if (chk.start) begin
                    state_d           = S_RUN;
                    seen_d            = '0;
                    err_cnt_d         = '0;
                    first_err_valid_d = 1'b0;
                    first_err_idx_d   = '0;
`ifdef CHK_ORDER_EN
                    next_idx_d        = '0;
                    order_err_d       = 1'b0;
`endif
                end
            end

            // start is deliberately not looked at here.
            S_RUN: begin
                if (chk.vec_valid) begin
                    seen_d = seen_q | vec_onehot;

                    if (mismatch) begin
                        if (!err_cnt_full) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                        if (!first_err_valid_q) begin
                            first_err_valid_d = 1'b1;
                            first_err_idx_d   = chk.vec;
                        end
                    end

`ifdef CHK_ORDER_EN
                    if (chk.vec != next_idx_q) begin
                        order_err_d = 1'b1;
                    end
                    // Wraps naturally at N_IN bits.
                    next_idx_d = chk.vec + 1'b1;
`endif

                    // Completion is decided on the updated bitmap, so the
                    // final sample is already counted when DONE is entered.
                    if (&seen_d) begin
                        state_d = S_DONE;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples the pre-edge values, regardless of statement order.
        if (rst) begin
            state_q           <= S_IDLE;
            // NOTE: the coverage bitmap is part of the visible reset state, so
            // it is cleared here like any control register.
            seen_q            <= '0;
            err_cnt_q         <= '0;
            first_err_valid_q <= 1'b0;
            first_err_idx_q   <= '0;
`ifdef CHK_ORDER_EN
            next_idx_q        <= '0;
            order_err_q       <= 1'b0;
`endif
        end else begin
            state_q           <= state_d;
            seen_q            <= seen_d;
            err_cnt_q         <= err_cnt_d;
            first_err_valid_q <= first_err_valid_d;
            first_err_idx_q   <= first_err_idx_d;
`ifdef CHK_ORDER_EN
            next_idx_q        <= next_idx_d;
            order_err_q       <= order_err_d;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign chk.busy            = (state_q == S_RUN);
    assign chk.done            = (state_q == S_DONE);
    assign chk.err_count       = err_cnt_q;
    assign chk.first_err_valid = first_err_valid_q;
    assign chk.first_err_idx   = first_err_idx_q;
`ifdef CHK_ORDER_EN
    assign chk.order_err       = order_err_q;
    assign chk.pass            = (state_q == S_DONE) && (err_cnt_q == '0)
                                 && !order_err_q;
`else
    assign chk.pass            = (state_q == S_DONE) && (err_cnt_q == '0);
`endif

endmodule

// File: tb/tb_truth_table_checker.sv
// -----------------------------------------------------------------------------
// tb_truth_table_checker
//
// Self-checking bench for truth_table_checker (N_IN=4, EXPECTED=16'h6996,
// CNT_W=8). A behavioural model built from run/coverage/error bookkeeping
// predicts all outputs; directed scenarios also check fixed expected values.
// Define CHK_ORDER_EN to include the in-order scenario.
// -----------------------------------------------------------------------------
module tb_truth_table_checker;

    localparam int          N_IN    = 4;
    localparam int          CNT_W   = 8;
    localparam logic [15:0] EXP_TAB = 16'h6996;
    localparam int          SAT_MAX = 255;

    logic clk;
    logic rst;

    truth_table_checker_if #(.N_IN(N_IN), .CNT_W(CNT_W)) bus ();

    truth_table_checker #(
        .N_IN    (N_IN),
        .EXPECTED(EXP_TAB),
        .CNT_W   (CNT_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .chk(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // ---------------------------------------------------------------- model
    bit         m_running;
    bit         m_done;
    bit         m_seen [16];
    int         m_err;
    bit         m_fv;
    logic [3:0] m_fi;
    bit         m_ord;
    int         m_next;

    function automatic int seen_count();
        int n = 0;
        for (int i = 0; i < 16; i++) n += m_seen[i] ? 1 : 0;
        return n;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < 16; i++) m_seen[i] = 1'b0;
        m_err  = 0;
        m_fv   = 1'b0;
        m_fi   = '0;
        m_ord  = 1'b0;
        m_next = 0;
    endfunction

    // Predict the effect of one rising edge given the inputs now applied.
    function automatic void model_edge();
        int v;
        v = int'(bus.vec);
        if (rst) begin
            model_clear();
            m_running = 1'b0;
            m_done    = 1'b0;
        end else if (!m_running) begin
            if (bus.start) begin
                model_clear();
                m_running = 1'b1;
                m_done    = 1'b0;
            end
        end else if (bus.vec_valid) begin
            m_seen[v] = 1'b1;
            if (bus.resp != EXP_TAB[v]) begin
                if (m_err < SAT_MAX) m_err++;
                if (!m_fv) begin
                    m_fv = 1'b1;
                    m_fi = bus.vec;
                end
            end
            if (v != m_next) m_ord = 1'b1;
            m_next = (v + 1) % 16;
            if (seen_count() == 16) begin
                m_running = 1'b0;
                m_done    = 1'b1;
            end
        end
    endfunction

    function automatic logic [16:0] model_snap();
        bit ord;
        bit pass;
`ifdef CHK_ORDER_EN
        ord = m_ord;
`else
        ord = 1'b0;
`endif
        pass = m_done && (m_err == 0) && !ord;
        return {m_running, m_done, pass, 8'(m_err), m_fv, m_fi, ord};
    endfunction

    function automatic logic [16:0] dut_snap();
        logic ord;
`ifdef CHK_ORDER_EN
        ord = bus.order_err;
`else
        ord = 1'b0;
`endif
        return {bus.busy, bus.done, bus.pass, bus.err_count,
                bus.first_err_valid, bus.first_err_idx, ord};
    endfunction

    // ------------------------------------------------------------- driving
    task automatic drive(input logic st, input logic vv, input logic [3:0] v,
                         input logic r, input logic rs = 1'b0);
        bus.start     = st;
        bus.vec_valid = vv;
        bus.vec       = v;
        bus.resp      = r;
        rst           = rs;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    function automatic logic good(input logic [3:0] v);
        return ^v;
    endfunction

    // --------------------------------------------------------------- tests
    task automatic test_reset();
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
        drive(1'b1, 1'b1, 4'd3, 1'b1, 1'b1);
        checks++;
        if (dut_snap() !== 17'h0) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", dut_snap(), 17'h0);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic test_clean_run();
        // A vector on the start edge must not be sampled (wrong resp here).
        drive(1'b1, 1'b1, 4'd0, 1'b1);
        checks++;
        if (bus.busy !== 1'b1 || bus.err_count !== 8'd0) begin
            errors++;
            $display("FAIL clean_start: busy %b err %0d want 1 0",
                     bus.busy, bus.err_count);
        end
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), good(4'(i)));
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL clean_run v%0d: got %h want %h", i, dut_snap(), model_snap());
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b1 || bus.err_count !== 8'd0 ||
            bus.first_err_valid !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL clean_verdict: done %b pass %b err %0d fev %b busy %b want 1 1 0 0 0",
                     bus.done, bus.pass, bus.err_count, bus.first_err_valid, bus.busy);
        end
    endtask

    task automatic test_two_errors();
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(i), good(4'(i)) ^ (i == 5 || i == 9));
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL two_err v%0d: got %h want %h", i, dut_snap(), model_snap());
            end
        end
        checks++;
        if (bus.err_count !== 8'd2 || bus.first_err_idx !== 4'd5 ||
            bus.first_err_valid !== 1'b1 || bus.pass !== 1'b0 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL two_err_verdict: err %0d idx %0d fev %b pass %b done %b want 2 5 1 0 1",
                     bus.err_count, bus.first_err_idx, bus.first_err_valid, bus.pass, bus.done);
        end
    endtask

    task automatic test_duplicates();
        logic [3:0] seq [18];
        logic       bad [18];
        for (int i = 0; i < 15; i++) begin
            seq[i] = 4'(i);
            bad[i] = 1'b0;
        end
        seq[15] = 4'd3;  bad[15] = 1'b1;
        seq[16] = 4'd3;  bad[16] = 1'b1;
        seq[17] = 4'd15; bad[17] = 1'b0;
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 18; i++) begin
            drive(1'b0, 1'b1, seq[i], good(seq[i]) ^ bad[i]);
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL dup step%0d: got %h want %h", i, dut_snap(), model_snap());
            end
            if (i == 16) begin
                checks++;
                if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
                    errors++;
                    $display("FAIL dup_busy: busy %b done %b want 1 0", bus.busy, bus.done);
                end
            end
        end
        checks++;
        if (bus.err_count !== 8'd2 || bus.done !== 1'b1 || bus.pass !== 1'b0 ||
            bus.first_err_idx !== 4'd3) begin
            errors++;
            $display("FAIL dup_verdict: err %0d done %b pass %b idx %0d want 2 1 0 3",
                     bus.err_count, bus.done, bus.pass, bus.first_err_idx);
        end
    endtask

    task automatic test_mid_run_reset();
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 8; i++) drive(1'b0, 1'b1, 4'(i), ~good(4'(i)));
        drive(1'b0, 1'b1, 4'd8, 1'b1, 1'b1);
        checks++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.err_count !== 8'd0 ||
            bus.first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst: busy %b done %b err %0d fev %b want 0 0 0 0",
                     bus.busy, bus.done, bus.err_count, bus.first_err_valid);
        end
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i), ~good(4'(i)));
        checks++;
        if (dut_snap() !== 17'h0 || dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL midrst_idle: got %h want %h", dut_snap(), 17'h0);
        end
    endtask

    task automatic test_ignored_inputs();
        // start held high throughout the run must be ignored.
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 15; i >= 0; i--) begin
            drive(1'b1, 1'b1, 4'(i), (i == 7) ? ~good(4'(i)) : good(4'(i)));
            checks++;
            if (dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL start_in_run v%0d: got %h want %h", i, dut_snap(), model_snap());
            end
        end
        // Samples in DONE must not disturb the held result.
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, 4'(i), ~good(4'(i)));
        checks++;
        if (bus.done !== 1'b1 || bus.err_count !== 8'd1 || bus.first_err_idx !== 4'd7 ||
            dut_snap() !== model_snap()) begin
            errors++;
            $display("FAIL done_hold: done %b err %0d idx %0d want 1 1 7",
                     bus.done, bus.err_count, bus.first_err_idx);
        end
        // Restart from DONE clears results.
        drive(1'b1, 1'b1, 4'd2, 1'b1);
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1 || bus.err_count !== 8'd0 ||
            bus.first_err_valid !== 1'b0) begin
            errors++;
            $display("FAIL restart: done %b busy %b err %0d fev %b want 0 1 0 0",
                     bus.done, bus.busy, bus.err_count, bus.first_err_valid);
        end
        drive(1'b0, 1'b0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic test_saturation();
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 300; i++) drive(1'b0, 1'b1, 4'd0, ~good(4'd0));
        checks++;
        if (bus.err_count !== 8'd255 || bus.busy !== 1'b1) begin
            errors++;
            $display("FAIL sat_count: err %0d busy %b want 255 1", bus.err_count, bus.busy);
        end
        for (int i = 1; i < 16; i++) drive(1'b0, 1'b1, 4'(i), good(4'(i)));
        checks++;
        if (dut_snap() !== model_snap() || bus.done !== 1'b1 || bus.err_count !== 8'd255) begin
            errors++;
            $display("FAIL sat_done: got %h want %h", dut_snap(), model_snap());
        end
    endtask

    task automatic test_random();
        int perm [16];
        for (int run = 0; run < 6; run++) begin
            drive(1'b1, 1'b0, 4'd0, 1'b0);
            for (int c = 0; c < 40; c++) begin
                logic [3:0] v;
                v = 4'($urandom_range(0, 15));
                drive(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 3) != 0), v,
                      good(v) ^ 1'($urandom_range(0, 9) == 0));
                checks++;
                if (dut_snap() !== model_snap()) begin
                    errors++;
                    $display("FAIL rand r%0d c%0d: got %h want %h", run, c, dut_snap(), model_snap());
                end
            end
            // Finish coverage with a shuffled sweep.
            for (int i = 0; i < 16; i++) perm[i] = i;
            for (int i = 15; i > 0; i--) begin
                int j;
                int t;
                j = $urandom_range(0, i);
                t = perm[i]; perm[i] = perm[j]; perm[j] = t;
            end
            for (int i = 0; i < 16; i++) begin
                drive(1'b0, 1'b1, 4'(perm[i]),
                      good(4'(perm[i])) ^ 1'($urandom_range(0, 15) == 0));
                checks++;
                if (dut_snap() !== model_snap()) begin
                    errors++;
                    $display("FAIL rand_sweep r%0d i%0d: got %h want %h", run, i,
                             dut_snap(), model_snap());
                end
            end
        end
    endtask

`ifdef CHK_ORDER_EN
    task automatic test_order();
        int seq [16];
        seq[0] = 0; seq[1] = 1; seq[2] = 3; seq[3] = 2;
        for (int i = 4; i < 16; i++) seq[i] = i;
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            drive(1'b0, 1'b1, 4'(seq[i]), good(4'(seq[i])));
            checks++;
            if (bus.order_err !== (i >= 2) || dut_snap() !== model_snap()) begin
                errors++;
                $display("FAIL order step%0d: order_err %b got %h want %h", i,
                         bus.order_err, dut_snap(), model_snap());
            end
        end
        checks++;
        if (bus.done !== 1'b1 || bus.pass !== 1'b0 || bus.err_count !== 8'd0) begin
            errors++;
            $display("FAIL order_verdict: done %b pass %b err %0d want 1 0 0",
                     bus.done, bus.pass, bus.err_count);
        end
        drive(1'b1, 1'b0, 4'd0, 1'b0);
        for (int i = 0; i < 16; i++) drive(1'b0, 1'b1, 4'(i), good(4'(i)));
        checks++;
        if (bus.order_err !== 1'b0 || bus.pass !== 1'b1 || bus.done !== 1'b1) begin
            errors++;
            $display("FAIL order_rerun: order_err %b pass %b done %b want 0 1 1",
                     bus.order_err, bus.pass, bus.done);
        end
    endtask
`endif

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.vec_valid = 1'b0;
        bus.vec       = '0;
        bus.resp      = 1'b0;
        m_running     = 1'b0;
        m_done        = 1'b0;
        model_clear();

        test_reset();
        test_clean_run();
        test_two_errors();
        test_duplicates();
        test_mid_run_reset();
        test_ignored_inputs();
        test_saturation();
        test_random();
`ifdef CHK_ORDER_EN
        test_order();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
